// File: rtl/crc_802_11_mac_rx.sv
// -----------------------------------------------------------------------------
// crc_802_11_mac_rx
//
// Serial receive-side FCS checker for an 802.11-style MAC. A frame is a run of
// consecutive cycles with i_in_vld=1 carrying the payload followed by a 32-bit
// FCS (MSB of each byte first). The block runs a CRC-32 LFSR over the whole
// frame, forwards the payload through a 32-bit delay line so the trailing FCS
// is stripped, and reports the check result with a one-cycle o_done pulse.
//
// Parameters
//   CNT_W      width of the received-bit counter (must be >= 6)
//
// Ports
//   i_clk      clock; all state changes on the rising edge
//   i_rst_n    synchronous active-low reset
//   i_in_vld   frame valid, high for every bit of one frame
//   i_in       serial frame bit
//   o_out_vld  qualifies o_out
//   o_out      forwarded payload bit (FCS stripped), 33 valid cycles late
//   o_done     one-cycle end-of-frame pulse
//   o_fcs_ok   FCS good, valid while o_done=1, otherwise 0
//   o_len_err  frame shorter than 33 bits, valid while o_done=1, otherwise 0
//   o_bit_cnt  bits received in the current or last frame (saturating)
// -----------------------------------------------------------------------------
module crc_802_11_mac_rx #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_vld,
  input  logic             i_in,
  output logic             o_out_vld,
  output logic             o_out,
  output logic             o_done,
  output logic             o_fcs_ok,
  output logic             o_len_err,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_SEED    = 32'hFFFF_FFFF;
  // Running the LFSR over payload followed by its complemented CRC always
  // leaves this constant behind, so no FCS extraction is needed.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  // A frame needs at least one payload bit on top of the 32-bit FCS.
  localparam logic [CNT_W-1:0] MIN_LEN   = CNT_W'(33);
  // Once 32 bits are buffered, the oldest one is known to be payload.
  localparam logic [CNT_W-1:0] FWD_START = CNT_W'(32);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  state_e           state_q;
  logic [31:0]      crc_q,  crc_d;
  logic [31:0]      dly_q;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             out_vld_q, out_q;
  logic             done_q, fcs_ok_q, len_err_q;
  logic             fwd_d;
  logic             short_frame;

  // One MSB-first LFSR step of the non-reflected CRC-32.
  function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                           input logic        din);
    logic fb;
    fb = crc[31] ^ din;
    return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
  endfunction

  // Next-state values used whenever a valid bit is absorbed. In IDLE the
  // incoming bit is the first of a new frame, so the LFSR restarts from the
  // seed and the counter restarts at 1.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first, so
    // no storage (latch) is inferred for combinational logic.
    crc_d = crc_step(crc_q, i_in);
    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    if (state_q == ST_IDLE) begin
      crc_d = crc_step(CRC_SEED, i_in);
      cnt_d = CNT_ONE;
    end
  end

  // Forward the oldest buffered bit only while the frame is still running
  // and more than 32 bits will have arrived including this one. Whatever is
  // left in the delay line at frame end is the FCS and is dropped.
  assign fwd_d       = (state_q == ST_RECV) && i_in_vld && (cnt_q >= FWD_START);
  assign short_frame = (cnt_q < MIN_LEN);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: the delay line is only 32 flops, not a RAM, so it is reset
      // along with everything else; a mid-frame reset aborts silently.
      state_q   <= ST_IDLE;
      crc_q     <= CRC_SEED;
      dly_q     <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
      fcs_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      // Status flags are pulses: cleared unless frame end sets them below.
      done_q    <= 1'b0;
      fcs_ok_q  <= 1'b0;
      len_err_q <= 1'b0;

      out_vld_q <= fwd_d;
      out_q     <= fwd_d ? dly_q[31] : 1'b0;

      if (i_in_vld) begin
        crc_q <= crc_d;
        cnt_q <= cnt_d;
        dly_q <= {dly_q[30:0], i_in};
      end

      unique case (state_q)
        ST_IDLE: begin
          // A valid bit here also covers the cycle o_done is high, so
          // back-to-back frames separated by one idle cycle are accepted.
          if (i_in_vld) state_q <= ST_RECV;
        end
        ST_RECV: begin
          // Any gap ends the frame; cnt_q and crc_q still describe it here.
          if (!i_in_vld) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b1;
            len_err_q <= short_frame;
            fcs_ok_q  <= (crc_q == CRC_RESIDUE) && !short_frame;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_out_vld = out_vld_q;
  assign o_out     = out_q;
  assign o_done    = done_q;
  assign o_fcs_ok  = fcs_ok_q;
  assign o_len_err = len_err_q;
  assign o_bit_cnt = cnt_q;

endmodule

// File: tb/tb_crc_802_11_mac_rx.sv
// -----------------------------------------------------------------------------
// tb_crc_802_11_mac_rx
//
// Self-checking bench for crc_802_11_mac_rx. A table of frame records (payload,
// FCS, optional bit flip, expected status/count/forwarded bits) is applied in a
// loop, followed by hand-written back-to-back and reset-mid-frame sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_crc_802_11_mac_rx;

  localparam int CNT_W = 16;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [127:0] PAY_123 = 128'h313233343536373839;
  localparam logic [31:0]  FCS_123 = 32'hFC891918;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_in_vld;
  logic             i_in;
  logic             o_out_vld;
  logic             o_out;
  logic             o_done;
  logic             o_fcs_ok;
  logic             o_len_err;
  logic [CNT_W-1:0] o_bit_cnt;

  crc_802_11_mac_rx #(.CNT_W(CNT_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_in_vld  (i_in_vld),
    .i_in      (i_in),
    .o_out_vld (o_out_vld),
    .o_out     (o_out),
    .o_done    (o_done),
    .o_fcs_ok  (o_fcs_ok),
    .o_len_err (o_len_err),
    .o_bit_cnt (o_bit_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int spurious  = 0;
  bit rx_q[$];

  // Passive monitor: collects forwarded bits and counts o_done pulses and
  // status flags raised outside a pulse.
  always @(negedge i_clk) begin
    if (o_out_vld) rx_q.push_back(o_out);
    if (o_done) done_seen++;
    else if (o_fcs_ok || o_len_err) spurious++;
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: FCS = ~CRC over the payload, seed all ones.
  function automatic logic [31:0] tx_fcs(input logic [127:0] pay, input int nbits);
    logic [31:0] crc;
    logic        fb;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < nbits; i++) begin
      fb  = crc[31] ^ pay[nbits-1-i];
      crc = {crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return ~crc;
  endfunction

  // Entered at a falling edge; drives payload then FCS, then one low-vld
  // cycle, and returns at the falling edge where o_done must be high.
  task automatic drive_frame(input logic [127:0] pay, input int nbits,
                             input logic [31:0] fcs, input int flip);
    for (int i = 0; i < nbits; i++) begin
      i_in_vld = 1'b1;
      i_in     = pay[nbits-1-i] ^ (i == flip);
      @(negedge i_clk);
    end
    for (int i = 0; i < 32; i++) begin
      i_in_vld = 1'b1;
      i_in     = fcs[31-i];
      @(negedge i_clk);
    end
    i_in_vld = 1'b0;
    i_in     = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    i_in_vld = 1'b0;
    i_in     = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  // Pops nbits forwarded bits and compares them with the payload as sent.
  task automatic expect_payload(input string name, input logic [127:0] pay,
                                input int nbits, input int flip);
    logic [127:0] got, exp;
    got = '0;
    exp = pay;
    if (flip >= 0) exp[nbits-1-flip] = ~exp[nbits-1-flip];
    for (int i = 0; i < nbits; i++) begin
      if (rx_q.size() > 0) got = {got[126:0], rx_q.pop_front()};
      else                 got = {got[126:0], 1'bx};
    end
    check(name, got, exp);
  endtask

  typedef struct {
    logic [127:0] pay;
    int           nbits;
    bit           use_model;
    logic [31:0]  fcs;
    int           flip;
    bit           exp_ok;
    bit           exp_len;
    int           exp_cnt;
    int           exp_pulses;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] fcs;
    int          d0;

    vecs[0] = '{pay: PAY_123, nbits: 72, use_model: 0, fcs: FCS_123, flip: -1,
                exp_ok: 1, exp_len: 0, exp_cnt: 104, exp_pulses: 72};
    vecs[1] = '{pay: PAY_123, nbits: 72, use_model: 0, fcs: FCS_123, flip: 5,
                exp_ok: 0, exp_len: 0, exp_cnt: 104, exp_pulses: 72};
    vecs[2] = '{pay: PAY_123, nbits: 72, use_model: 0, fcs: 32'hFC891919, flip: -1,
                exp_ok: 0, exp_len: 0, exp_cnt: 104, exp_pulses: 72};
    vecs[3] = '{pay: 128'h0, nbits: 0, use_model: 0, fcs: 32'hFFFFFFFF, flip: -1,
                exp_ok: 0, exp_len: 1, exp_cnt: 32, exp_pulses: 0};
    vecs[4] = '{pay: 128'h1, nbits: 1, use_model: 1, fcs: 32'h0, flip: -1,
                exp_ok: 1, exp_len: 0, exp_cnt: 33, exp_pulses: 1};
    vecs[5] = '{pay: 128'hDEADBEEF0123456789AB, nbits: 80, use_model: 1, fcs: 32'h0,
                flip: -1, exp_ok: 1, exp_len: 0, exp_cnt: 112, exp_pulses: 80};

    // Reset state.
    i_rst_n  = 1'b0;
    i_in_vld = 1'b0;
    i_in     = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_out_vld", o_out_vld, 0);
    check("rst_out",     o_out,     0);
    check("rst_done",    o_done,    0);
    check("rst_fcs_ok",  o_fcs_ok,  0);
    check("rst_len_err", o_len_err, 0);
    check("rst_bit_cnt", o_bit_cnt, 0);
    i_rst_n = 1'b1;
    idle(2);
    rx_q.delete();

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      fcs = vecs[v].use_model ? tx_fcs(vecs[v].pay, vecs[v].nbits) : vecs[v].fcs;
      drive_frame(vecs[v].pay, vecs[v].nbits, fcs, vecs[v].flip);
      check($sformatf("vec%0d_done", v),    o_done,    1);
      check($sformatf("vec%0d_fcs_ok", v),  o_fcs_ok,  vecs[v].exp_ok);
      check($sformatf("vec%0d_len_err", v), o_len_err, vecs[v].exp_len);
      check($sformatf("vec%0d_bit_cnt", v), o_bit_cnt, vecs[v].exp_cnt);
      idle(1);
      check($sformatf("vec%0d_done_1cyc", v), o_done, 0);
      idle(2);
      check($sformatf("vec%0d_cnt_hold", v), o_bit_cnt, vecs[v].exp_cnt);
      check($sformatf("vec%0d_pulses", v), rx_q.size(), vecs[v].exp_pulses);
      expect_payload($sformatf("vec%0d_payload", v), vecs[v].pay, vecs[v].nbits,
                     vecs[v].flip);
      rx_q.delete();
    end

    // Back-to-back: exactly one low-vld cycle between two good frames.
    d0 = done_seen;
    drive_frame(PAY_123, 72, FCS_123, -1);
    check("b2b_done_a",   o_done,   1);
    check("b2b_fcs_ok_a", o_fcs_ok, 1);
    drive_frame(PAY_123, 72, FCS_123, -1);
    check("b2b_done_b",    o_done,    1);
    check("b2b_fcs_ok_b",  o_fcs_ok,  1);
    check("b2b_bit_cnt_b", o_bit_cnt, 104);
    idle(3);
    check("b2b_pulse_count", done_seen - d0, 2);
    check("b2b_out_bits", rx_q.size(), 144);
    expect_payload("b2b_payload_a", PAY_123, 72, -1);
    expect_payload("b2b_payload_b", PAY_123, 72, -1);
    rx_q.delete();

    // Reset mid-frame after 40 bits, vld held high through reset and release.
    d0 = done_seen;
    for (int i = 0; i < 40; i++) begin
      i_in_vld = 1'b1;
      i_in     = PAY_123[71-i];
      @(negedge i_clk);
    end
    i_rst_n = 1'b0;
    i_in    = 1'b1;
    repeat (2) @(negedge i_clk);
    check("rstmid_bit_cnt", o_bit_cnt, 0);
    check("rstmid_out_vld", o_out_vld, 0);
    check("rstmid_fwd_before", rx_q.size(), 8);
    rx_q.delete();
    i_rst_n = 1'b1;
    drive_frame(PAY_123, 72, FCS_123, -1);
    check("rstmid_done",    o_done,    1);
    check("rstmid_fcs_ok",  o_fcs_ok,  1);
    check("rstmid_bit_cnt2", o_bit_cnt, 104);
    idle(3);
    check("rstmid_pulse_count", done_seen - d0, 1);
    check("rstmid_out_bits", rx_q.size(), 72);
    expect_payload("rstmid_payload", PAY_123, 72, -1);
    rx_q.delete();

    check("status_outside_done", spurious, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_802_11_mac_rx.md
CRC_802_11_MAC_RX -- requirements
Module: crc_802_11_mac_rx

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the received-bit counter.
REQ-002 The block SHALL have port i_clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port i_in_vld, input, 1 bit: frame-valid; high for every bit of one frame (payload followed by 32-bit FCS).
REQ-005 The block SHALL have port i_in, input, 1 bit: serial frame bit, sampled when i_in_vld=1, MSB of each byte first.
REQ-006 The block SHALL have port o_out_vld, output, 1 bit: qualifies o_out.
REQ-007 The block SHALL have port o_out, output, 1 bit: forwarded payload bit, FCS stripped.
REQ-008 The block SHALL have port o_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-009 The block SHALL have port o_fcs_ok, output, 1 bit: FCS check result, valid while o_done=1.
REQ-010 The block SHALL have port o_len_err, output, 1 bit: frame shorter than 33 bits, valid while o_done=1.
REQ-011 The block SHALL have port o_bit_cnt, output, CNT_W bits: total bits received in the current or last frame.

Function
REQ-012 The CRC SHALL be CRC-32 with polynomial 0x04C11DB7, non-reflected, MSB-first LFSR: fb = crc[31]^i_in; crc <= {crc[30:0],1'b0} ^ (fb ? 0x04C11DB7 : 0).
REQ-013 The FCS convention SHALL match the team's transmitter: FCS = ~CRC over the payload, init 0xFFFFFFFF, sent bit 31 first.
REQ-014 The FSM SHALL have two states, IDLE and RECV.
REQ-015 In IDLE with i_in_vld=1, the FSM SHALL go to RECV; the LFSR SHALL absorb i_in from a seed of 0xFFFFFFFF; o_bit_cnt SHALL load 1.
REQ-016 In RECV with i_in_vld=1, the LFSR SHALL absorb i_in and o_bit_cnt SHALL increment, saturating at all-ones.
REQ-017 In RECV with i_in_vld=0 (frame end), the FSM SHALL go to IDLE and o_done SHALL be 1 in the next cycle only.
REQ-018 With that o_done pulse, o_fcs_ok SHALL = (crc == 0xC704DD7B) && !o_len_err, and o_len_err SHALL = (bit count < 33).
REQ-019 o_fcs_ok and o_len_err SHALL be 0 whenever o_done=0.
REQ-020 If i_in_vld=1 in the cycle o_done is high, that bit SHALL start a new frame per REQ-015 without affecting the pulse being reported.
REQ-021 A 32-bit delay line SHALL shift in every valid bit; once more than 32 bits of the frame have been received, each valid input cycle SHALL drive o_out_vld=1 next cycle, with o_out = the bit received 32 valid cycles earlier.
REQ-022 Bits still in the delay line at frame end (the FCS) SHALL never be output.
REQ-023 o_out_vld SHALL be 0 in cycles where i_in_vld was 0 in the previous cycle.
REQ-024 Payload latency SHALL be 33 valid-bit cycles: bit n appears on o_out in the cycle after bit n+32 is sampled.
REQ-025 o_bit_cnt SHALL hold its value in IDLE until the next frame starts.
REQ-026 A one-cycle gap in i_in_vld SHALL always terminate the frame; there is no stall.

Reset
REQ-027 While i_rst_n=0 at a rising edge, the next state SHALL be: FSM IDLE, LFSR 0xFFFFFFFF, delay line 0, o_out_vld=0, o_out=0, o_done=0, o_fcs_ok=0, o_len_err=0, o_bit_cnt=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without an o_done pulse.
REQ-029 Bits arriving after reset releases with i_in_vld still high SHALL start a new frame.

Verification
REQ-030 Scenario (good frame): ASCII "123456789" (0x31..0x39, 72 bits) + FCS 0xFC891918 -> o_done one cycle after vld falls, o_fcs_ok=1, o_len_err=0, o_bit_cnt=104, and 72 o_out_vld pulses reproducing 0x31..0x39 in order.
REQ-031 Scenario (corrupted bit): same frame with payload bit 5 inverted -> o_fcs_ok=0, o_done=1, o_bit_cnt=104.
REQ-032 Scenario (short frame): 32 bits 0xFFFFFFFF -> o_len_err=1, o_fcs_ok=0, no o_out_vld pulses.
REQ-033 Scenario (back-to-back): two good frames separated by exactly one low-vld cycle -> two o_done pulses, both o_fcs_ok=1, 144 payload bits output.
REQ-034 Scenario (reset mid-frame): i_rst_n=0 for 2 cycles after 40 bits, then a good frame -> no o_done for the aborted frame, the second frame gives o_fcs_ok=1.
REQ-035 Scenario (loopback): the team's transmitter output fed to this block on the 80-bit stimulus -> o_fcs_ok=1 and the payload matches the transmitter input.
